event_drain: RTL and testbench



---
 rtl/event_drain.sv | 115 +++++++++++
 tb/tb_event_drain.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/event_drain.sv
// Sticky event collector that drains pending flags one at a time, round-robin, over valid/ready.
// Optional macro EVENT_DRAIN_TIMESTAMP_EN adds a per-event capture timestamp on evt_ts.
module event_drain #(
  parameter int N_EVT = 8,
  parameter int IDX_W = 3,
  parameter int CNT_W = 8,
  parameter int TS_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_EVT-1:0] set_i,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_idx,
  output logic [N_EVT-1:0] pending,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
`ifdef EVENT_DRAIN_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]  evt_ts
`endif
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OFFER = 1'b1;

  if (N_EVT < 2 || TS_W < 1 || (1 << IDX_W) < N_EVT) begin : g_bad_param
    $error("event_drain: illegal parameter combination");
  end

  logic [0:0]       r_state;
  logic [N_EVT-1:0] r_pending;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_drop;

  logic [N_EVT-1:0] w_rot;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_sel;
  logic             w_any;
  logic             w_load;
  logic [N_EVT-1:0] w_load_vec;
  logic             w_drop;
  logic [IDX_W-1:0] w_ptr_nxt;

  // Rotate pending so bit 0 is the flag at ptr; lowest set bit is the winner.
  always_comb begin
    w_rot = N_EVT'({r_pending, r_pending} >> r_ptr);
    w_off = '0;
    for (int k = N_EVT - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IDX_W'(k);
    end
    w_any = |r_pending;
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (IDX_W+1)'(N_EVT)) w_sel = IDX_W'(w_sum - (IDX_W+1)'(N_EVT));
    else                            w_sel = IDX_W'(w_sum);
  end

  assign w_load     = w_any && ((r_state == S_IDLE) || evt_ready);
  assign w_load_vec = w_load ? (N_EVT'(1) << w_sel) : '0;
  // A set landing on a bit being loaded is a fresh occurrence, not a loss.
  assign w_drop     = |(set_i & r_pending & ~w_load_vec);
  assign w_ptr_nxt  = (w_sel == IDX_W'(N_EVT - 1)) ? '0 : w_sel + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_drop    <= '0;
    end else begin
      r_pending <= set_i | (r_pending & ~w_load_vec);
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;
      if (w_load) begin
        r_state <= S_OFFER;
        r_idx   <= w_sel;
        r_ptr   <= w_ptr_nxt;
      end else if ((r_state == S_OFFER) && evt_ready) begin
        r_state <= S_IDLE;
      end
    end
  end

`ifdef EVENT_DRAIN_TIMESTAMP_EN
  logic [TS_W-1:0]             r_ts;
  logic [N_EVT-1:0][TS_W-1:0]  r_ts_mem;
  logic [TS_W-1:0]             r_evt_ts;

  // Capture only when a set starts a new occurrence; repeats while pending keep the first stamp.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts     <= '0;
      r_ts_mem <= '0;
      r_evt_ts <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      for (int i = 0; i < N_EVT; i++) begin
        if (set_i[i] && (!r_pending[i] || w_load_vec[i])) r_ts_mem[i] <= r_ts;
      end
      if (w_load) r_evt_ts <= r_ts_mem[w_sel];
    end
  end

  assign evt_ts = r_evt_ts;
`endif

  assign evt_valid = (r_state == S_OFFER);
  assign evt_idx   = r_idx;
  assign pending   = r_pending;
  assign drop_cnt  = r_drop;
  assign busy      = evt_valid | (|r_pending);

endmodule

// File: tb/tb_event_drain.sv
// Directed bench for event_drain: stimulus pushes expected indices, a negedge monitor pops on handshake.
module tb_event_drain;
  localparam int N_EVT = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 8;
  localparam int TS_W  = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_EVT-1:0] set_i;
  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_idx;
  logic [N_EVT-1:0] pending;
  logic [CNT_W-1:0] drop_cnt;
  logic             busy;
`ifdef EVENT_DRAIN_TIMESTAMP_EN
  logic [TS_W-1:0]  evt_ts;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  event_drain #(.N_EVT(N_EVT), .IDX_W(IDX_W), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .set_i     (set_i),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_idx   (evt_idx),
    .pending   (pending),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
`ifdef EVENT_DRAIN_TIMESTAMP_EN
    ,
    .evt_ts    (evt_ts)
`endif
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted handshake must match the next expected index.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got idx %0d expected none", evt_idx);
        end else begin
          check("sb_idx", 32'(evt_idx), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; set_i = '0; evt_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid",   32'(evt_valid), 0);
    check("rst_idx",     32'(evt_idx),   0);
    check("rst_pending", 32'(pending),   0);
    check("rst_drop",    32'(drop_cnt),  0);
    check("rst_busy",    32'(busy),      0);
    reset = 1'b0;

    // Single event: pending after 1 edge, valid after 2, gone after accept.
    evt_ready = 1'b1; set_i = 8'h04; exp_q.push_back(2);
    tick(); set_i = '0;
    check("t1_pend",  32'(pending),   32'h04);
    check("t1_vld0",  32'(evt_valid), 0);
    tick();
    check("t1_vld1",  32'(evt_valid), 1);
    check("t1_idx",   32'(evt_idx),   2);
    check("t1_pend0", 32'(pending),   0);
    tick();
    check("t1_vld2",  32'(evt_valid), 0);
    check("t1_busy",  32'(busy),      0);

    // Fresh reset so ptr=0, then all eight back-to-back.
    reset = 1'b1; tick(); reset = 1'b0;
    set_i = 8'hFF;
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    tick(); set_i = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t2_nogap", {31'd0, evt_valid} + 32'(evt_idx << 1), 32'(1 + (i << 1)));
    end
    tick();
    check("t2_done", 32'(evt_valid), 0);
    check("t2_drop", 32'(drop_cnt),  0);

    // Backpressure: idx 0 held while ready low, then 0 and 1 drain.
    evt_ready = 1'b0; set_i = 8'h03; exp_q.push_back(0); exp_q.push_back(1);
    tick(); set_i = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold", {31'd0, evt_valid} + 32'(evt_idx << 1), 32'h1);
    end
    evt_ready = 1'b1;
    tick();
    check("t3_second", 32'(evt_idx), 1);
    tick();
    check("t3_done", 32'(evt_valid), 0);

    // Fairness: accept 5 (ptr becomes 6), then 0x21 must give 0 before 5.
    set_i = 8'h20; exp_q.push_back(5);
    tick(); set_i = '0; tick(); tick();
    set_i = 8'h21; exp_q.push_back(0); exp_q.push_back(5);
    tick(); set_i = '0;
    tick();
    check("t4_first", 32'(evt_idx), 0);
    tick(); tick();
    check("t4_done", 32'(evt_valid), 0);

    // Drops: bit 3 offered and held, re-set twice while pending, then saturate.
    evt_ready = 1'b0; set_i = 8'h08; exp_q.push_back(3);
    tick(); set_i = '0;
    tick();
    set_i = 8'h08; tick();
    check("t5_nodrop", 32'(drop_cnt), 0);
    tick(); set_i = '0;
    check("t5_drop1", 32'(drop_cnt), 1);
    set_i = 8'h08;
    repeat (300) tick();
    set_i = '0;
    check("t5_sat", 32'(drop_cnt), 255);
    exp_q.push_back(3);
    evt_ready = 1'b1;
    tick(); tick();
    check("t5_done", 32'(busy), 0);

    // Reset mid-offer with 0xF0 pending discards everything.
    evt_ready = 1'b0; set_i = 8'hF0;
    tick(); set_i = '0;
    tick();
    check("t6_offer", 32'(evt_valid), 1);
    reset = 1'b1;
    tick();
    check("t6_vld",  32'(evt_valid), 0);
    check("t6_pend", 32'(pending),   0);
    check("t6_drop", 32'(drop_cnt),  0);
    reset = 1'b0; evt_ready = 1'b1;
    repeat (3) tick();
    check("t6_quiet", 32'(busy), 0);
    set_i = 8'h10; exp_q.push_back(4);
    tick(); set_i = '0;
    tick();
    check("t6_idx", 32'(evt_idx), 4);
`ifdef EVENT_DRAIN_TIMESTAMP_EN
    check("t6_ts", 32'(evt_ts), 3);
`endif
    tick();
    check("t6_done", 32'(evt_valid), 0);

    repeat (2) tick();
    check("sb_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
